// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared types and constants for the BCD encode/decode blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;

    // Binary width needed to hold the largest value of an n-digit BCD word.
    function automatic int bcd_min_bin_w(input int digits);
        longint v;
        v = 1;
        for (int i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return $clog2(v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mac10.sv
// ============================================================================
//  Module      : bcd_mac10
//  Description : Combinational acc*10 + digit step, with optional bad-digit
//                flag when BCD_ERR_CHECK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int BIN_W = 7
) (
    input  logic [BIN_W-1:0]       acc,
    input  logic [BCD_DIGIT_W-1:0] digit,
`ifdef BCD_ERR_CHECK_EN
    output logic                   digit_bad,
`endif
    output logic [BIN_W-1:0]       sum
);

    localparam int c_WIDE_W = BIN_W + BCD_DIGIT_W;
    typedef logic [c_WIDE_W-1:0] wide_t;

    // x10 as shift-and-add in a widened domain, then wrapped back to BIN_W.
    assign sum = BIN_W'((wide_t'(acc) << 3) + (wide_t'(acc) << 1) + wide_t'(digit));

`ifdef BCD_ERR_CHECK_EN
    assign digit_bad = (digit > BCD_MAX);
`endif

endmodule

`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
// ============================================================================
//  Module      : bcd_to_bin_seq
//  Description : Sequential BCD-to-binary converter, one digit per clock,
//                valid/ready on both sides. Macro: BCD_ERR_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BIN_W-1:0]              bin_out,
    output logic                          err
);

    localparam int c_WORD_W = BCD_DIGIT_W * DIGITS;
    localparam int c_CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIGITS - 1);

    if (BIN_W < bcd_min_bin_w(DIGITS)) begin : g_bin_w_check
        $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
    end

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_WORD_W-1:0]    r_shift;
    logic [BIN_W-1:0]       r_acc;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [BIN_W-1:0]       r_bin_out;
    logic [BIN_W-1:0]       w_sum;
    logic [BCD_DIGIT_W-1:0] w_top;
    logic                   w_accept;
    logic                   w_last;

    assign w_top     = r_shift[c_WORD_W-1 -: BCD_DIGIT_W];
    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == '0);
    assign bin_out   = r_bin_out;

`ifdef BCD_ERR_CHECK_EN
    logic w_digit_bad;
    logic r_err_acc;
    logic r_err;

    bcd_mac10 #(.BIN_W(BIN_W)) u_mac10 (
        .acc       (r_acc),
        .digit     (w_top),
        .digit_bad (w_digit_bad),
        .sum       (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_acc <= 1'b0;
            r_err     <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_accept) r_err_acc <= 1'b0;
        end else if (r_state == CONV) begin
            r_err_acc <= r_err_acc | w_digit_bad;
            if (w_last) r_err <= r_err_acc | w_digit_bad;
        end
    end

    assign err = r_err;
`else
    bcd_mac10 #(.BIN_W(BIN_W)) u_mac10 (
        .acc   (r_acc),
        .digit (w_top),
        .sum   (w_sum)
    );

    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = CONV;
            CONV:    if (w_last) w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Shift register, accumulator, digit counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_bin_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift <= bcd_in;
                        r_acc   <= '0;
                        r_cnt   <= c_CNT_LAST;
                    end
                end
                CONV: begin
                    r_acc   <= w_sum;
                    r_shift <= r_shift << BCD_DIGIT_W;
                    if (w_last) r_bin_out <= w_sum;
                    else        r_cnt     <= r_cnt - c_CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
// ============================================================================
//  Module      : tb_bcd_to_bin_seq
//  Description : Self-checking bench for bcd_to_bin_seq (default and 3-digit).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_bin_seq;

`ifdef BCD_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] bcd_in = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [6:0] bin_out;
    logic       err;

    logic        iv3 = 1'b0;
    logic        ir3;
    logic [11:0] bcd3 = 12'h000;
    logic        ov3;
    logic [9:0]  bin3;
    logic        err3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bcd_to_bin_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .bcd_in(bcd_in), .out_valid(out_valid), .out_ready(out_ready),
        .bin_out(bin_out), .err(err)
    );

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3),
        .bcd_in(bcd3), .out_valid(ov3), .out_ready(1'b1),
        .bin_out(bin3), .err(err3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Value of a BCD word as plain decimal arithmetic, wrapped to bw bits.
    function automatic longint bcd_value(input logic [31:0] w, input int d, input int bw);
        longint v = 0;
        for (int i = d - 1; i >= 0; i--) v = v * 10 + longint'(w[4*i +: 4]);
        return v % (longint'(1) << bw);
    endfunction

    function automatic bit bcd_bad(input logic [31:0] w, input int d);
        bit b = 0;
        for (int i = 0; i < d; i++) if (w[4*i +: 4] > 4'd9) b = 1;
        return b;
    endfunction

    // Reference model for the default instance: cycles remaining, done flag, held result.
    int     m_left = 0;
    bit     m_done = 0;
    longint m_pend_val = 0, m_val = 0;
    bit     m_pend_err = 0, m_err = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0; m_done <= 0; m_val <= 0; m_err <= 0;
        end else if (m_left == 0 && !m_done) begin
            if (in_valid) begin
                m_left     <= 2;
                m_pend_val <= bcd_value({24'h0, bcd_in}, 2, 7);
                m_pend_err <= ERR_EN && bcd_bad({24'h0, bcd_in}, 2);
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1; m_val <= m_pend_val; m_err <= m_pend_err;
            end
        end else if (out_ready) begin
            m_done <= 0;
        end
    end

    always @(negedge clk) begin
        check("model in_ready", longint'(in_ready), longint'(!rst && m_left == 0 && !m_done));
        check("model out_valid", longint'(out_valid), longint'(m_done));
        check("model bin_out", longint'(bin_out), m_val);
        check("model err", longint'(err), longint'(m_err));
    end

    task automatic send(input logic [7:0] w, output int acc_cyc);
        bit ok = 0;
        in_valid = 1'b1;
        bcd_in   = w;
        for (int n = 0; n < 40; n++) begin
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        acc_cyc  = cyc;
        if (!ok) check("send timeout", 0, 1);
    endtask

    task automatic wait_ov(input int c0, output int lat);
        for (int n = 0; n < 40 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        if (!out_valid) check("out_valid timeout", 0, 1);
        lat = cyc - c0;
    endtask

    initial begin
        int c0, c1, lat;
        bit ok3;

        check("pin model 42", bcd_value(32'h42, 2, 7), 42);
        check("pin model 999", bcd_value(32'h999, 3, 10), 999);
        check("pin model 1A", bcd_value(32'h1A, 2, 7), 20);
        check("pin model bad 1A", longint'(bcd_bad(32'h1A, 2)), 1);

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", longint'(in_ready), 0);
        check("reset bin_out", longint'(bin_out), 0);
        rst = 1'b0;
        #1;
        check("in_ready after reset", longint'(in_ready), 1);

        send(8'h00, c0);
        wait_ov(c0, lat);
        check("lat 00", lat, 2);
        check("bin 00", longint'(bin_out), 0);
        check("err 00", longint'(err), 0);
        @(posedge clk); #1;

        send(8'h42, c0);
        wait_ov(c0, lat);
        check("bin 42", longint'(bin_out), 42);
        send(8'h99, c1);
        check("b2b spacing", c1 - c0, 4);
        wait_ov(c1, lat);
        check("bin 99", longint'(bin_out), 99);
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(8'h15, c0);
        wait_ov(c0, lat);
        in_valid = 1'b1;
        bcd_in   = 8'h33;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold out_valid", longint'(out_valid), 1);
            check("hold bin 15", longint'(bin_out), 15);
            check("hold in_ready", longint'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("released", longint'(out_valid), 0);
        check("in_ready after release", longint'(in_ready), 1);

        send(8'h1A, c0);
        wait_ov(c0, lat);
        check("bin 1A", longint'(bin_out), 20);
        check("err 1A", longint'(err), longint'(ERR_EN));
        @(posedge clk); #1;

        send(8'h77, c0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort bin_out", longint'(bin_out), 0);
        check("abort err", longint'(err), 0);
        for (int i = 0; i < 5; i++) begin
            check("abort no out_valid", longint'(out_valid), 0);
            @(posedge clk); #1;
        end
        send(8'h05, c0);
        wait_ov(c0, lat);
        check("bin 05", longint'(bin_out), 5);
        check("lat 05", lat, 2);

        iv3  = 1'b1;
        bcd3 = 12'h999;
        ok3  = ir3;
        @(posedge clk); #1;
        iv3 = 1'b0;
        c0  = cyc;
        check("d3 in_ready", longint'(ok3), 1);
        for (int n = 0; n < 40 && !ov3; n++) begin
            @(posedge clk); #1;
        end
        check("d3 lat", cyc - c0, 3);
        check("d3 bin 999", longint'(bin3), 999);
        check("d3 err", longint'(err3), 0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Sequential BCD-to-binary converter: accepts a packed multi-digit BCD word and returns its unsigned binary value. It performs one multiply-by-10-and-add step per clock. Valid/ready handshakes sit on both the input and output sides. It is the encode-direction partner of the lab's binary-to-BCD decoder and feeds numeric-entry results back into the binary datapath.

## Interface
- `DIGITS`, default 2: number of BCD digits in the input word (≥1).
- `BIN_W`, default 7: binary output width. Must satisfy `BIN_W ≥ ceil(log2(10^DIGITS))`; elaboration fails via assertion otherwise.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `in_valid`  in  1: `bcd_in` is valid.
- `in_ready`  out  1: the block can accept a word.
- `bcd_in`  in  `4*DIGITS`: packed BCD, most significant digit in the top nibble.
- `out_valid`  out  1: `bin_out` and `err` are valid.
- `out_ready`  in  1: the consumer accepts the result.
- `bin_out`  out  `BIN_W`: binary result.
- `err`  out  1: at least one input digit was greater than 9 (see Configuration).

## Operation
- The FSM has three states: `IDLE`, `CONV` and `DONE`. The reset state is `IDLE`.
- **IDLE**
  - `in_ready=1`.
  - On the edge where `in_valid && in_ready` is true:
    - capture `bcd_in` into the shift register;
    - set `acc=0`, `cnt=DIGITS-1` and the internal error flag to 0;
    - go to `CONV`.
- **CONV**
  - `in_ready=0`.
  - Each edge:
    - `acc <= acc*10 + top_nibble`, where `acc*10` is implemented as `(acc<<3)+(acc<<1)` at width `BIN_W+4`, then truncated to `BIN_W`;
    - shift the register left by 4;
    - set the error flag if `top_nibble>9`.
  - When `cnt==0`:
    - load `bin_out` with the final sum and load `err`;
    - go to `DONE`.
  - Otherwise, decrement `cnt`.
- **DONE**
  - `out_valid=1`. `bin_out` and `err` are stable until the output handshake.
  - On the edge where `out_valid && out_ready` is true, go to `IDLE`.
- There is no overlap between words. A new word is accepted only in `IDLE`.
- `in_ready` is combinational: `(state==IDLE) && !rst`.
- `bin_out` and `err` are registers. They change only on the `CONV`→`DONE` edge and hold their last values in `IDLE`.
- The arithmetic is unsigned. For valid BCD, the `BIN_W` constraint guarantees no overflow.
- Invalid digits (10–15) are accumulated at their raw value. The resulting `bin_out` is defined but not meaningful.

## Timing
- Reset values:
  - state = `IDLE`;
  - `out_valid=0`, `bin_out=0`, `err=0`;
  - `in_ready=0` while `rst=1`, and 1 on the first cycle after reset is released.
- Latency: if the input handshake happens at edge E0, `out_valid` goes high after edge E`DIGITS`.
- Throughput: at most one word per `DIGITS+2` cycles when `out_ready` is held at 1.
- Backpressure: with `out_ready=0` the block stays in `DONE` indefinitely and holds its outputs. `in_ready` stays 0.
- Reset asserted mid-conversion (in `CONV` or `DONE`):
  - the word is aborted on that edge and no `out_valid` is produced;
  - `bin_out` and `err` are cleared.
- `in_valid` while busy is ignored. The upstream block must hold the word until `in_ready`.
- `in_valid` is sampled only in `IDLE`. There is no combinational path from `in_valid` to `in_ready`.

## Configuration
- Macro: `BCD_ERR_CHECK_EN`.
- Defined: per-digit `>9` detection is compiled in. `err` is the OR of the detections over all digits of the word and is updated with `bin_out`.
- Undefined: the detection logic is removed and `err` is tied to 0. Conversion and timing are unchanged.

## Structure
- Package `bcd_pkg` contains:
  - the `state_t` enum (`IDLE`, `CONV`, `DONE`);
  - `localparam BCD_DIGIT_W=4`;
  - `localparam BCD_MAX=4'd9`.
- The shared package `bcd_pkg` is imported by the existing decoder-side logic where useful.
- Sub-module `bcd_mac10` is combinational. It takes `acc` and `digit` and produces `acc*10+digit`, plus `digit_bad` when `BCD_ERR_CHECK_EN` is defined. The FSM, counter and shift register stay in `bcd_to_bin_seq`.

## Test plan
- Defaults (`DIGITS=2`, `BIN_W=7`), `bcd_in=8'h00`, `out_ready=1` → `bin_out=0`, `err=0`, with `out_valid` 2 cycles after acceptance.
- Defaults, back-to-back words `8'h42` then `8'h99`, `out_ready=1` → results 42 then 99, second word accepted 4 cycles after the first.
- Defaults, `bcd_in=8'h15`, `out_ready=0` for 10 cycles → `out_valid` and `bin_out=15` held, `in_ready=0`; result released on the first cycle with `out_ready=1`.
- With `BCD_ERR_CHECK_EN` defined, `bcd_in=8'h1A` → `err=1`, `bin_out=20`. Without the macro → `err=0`, `bin_out=20`.
- `rst` pulsed 1 cycle after accepting `8'h77` → no `out_valid`, `bin_out=0`; the next word `8'h05` yields 5.
- `DIGITS=3`, `BIN_W=10`, `bcd_in=12'h999` → `bin_out=999`, `out_valid` 3 cycles after acceptance.
